// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control unit.
// Opcodes, mux-select codes and the state enum live here so the FSM and its helpers agree.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR,
    MEM_RD, WB_LW, MEM_WR, BRANCH, JUMP, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] SRCB_B      = 3'd0;
  localparam logic [2:0] SRCB_FOUR   = 3'd1;
  localparam logic [2:0] SRCB_SEXT   = 3'd2;
  localparam logic [2:0] SRCB_BRANCH = 3'd3;
  localparam logic [2:0] SRCB_MDR    = 3'd4;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam int WAIT_W = 4;

  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

  // Anything outside the supported subset parks the machine in HALT.
  function automatic state_t decode_dispatch(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return EXEC_R;
      OP_ADDI:      return EXEC_I;
      OP_LW, OP_SW: return ADDR;
      OP_BEQ:       return BRANCH;
      OP_J:         return JUMP;
      default:      return HALT;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_wait_counter.sv
// Memory wait-state down-counter: load, decrement, terminal-count flag.
// Shared by FETCH, MEM_RD and MEM_WR so every memory access holds for load_val+1 cycles.
module mc_wait_counter
  import mc_ctrl_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/write-back.
// Moore outputs decode from the state register and the wait counter's terminal count.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted
);

  // state  | meaning
  // RST    | held in reset, all outputs low
  // FETCH  | read instruction at PC, PC+4 on last cycle
  // DECODE | latch opcode, precompute branch target
  // EXEC_R | R-type ALU operation
  // WB_R   | write rd
  // EXEC_I | addi ALU operation
  // WB_I   | write rt
  // ADDR   | lw/sw effective address
  // MEM_RD | load data read
  // WB_LW  | write MDR to rt
  // MEM_WR | store data write
  // BRANCH | beq compare, conditional PC load
  // JUMP   | PC <- jump target
  // HALT   | unsupported opcode, terminal

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT);

  state_t     state;
  logic [5:0] op_q;
  logic       in_mem;
  logic       cnt_done;
  logic       last;

  // zero only gates pc_write_cond inside the datapath; this block stays Moore.
  logic unused_zero;
  assign unused_zero = zero;

  assign in_mem = is_mem_state(state);
  assign last   = in_mem && cnt_done;

  // Outside memory states the counter sits preloaded, so entry always starts at MEM_WAIT.
  mc_wait_counter #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (!in_mem || cnt_done),
    .load_val (WAIT_INIT),
    .dec      (in_mem && !cnt_done),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST;
      op_q  <= '0;
    end else begin
      case (state)
        RST:    state <= FETCH;
        FETCH:  if (cnt_done) state <= DECODE;
        DECODE: begin
          op_q  <= opcode;
          state <= decode_dispatch(opcode);
        end
        EXEC_R: state <= WB_R;
        WB_R:   state <= FETCH;
        EXEC_I: state <= WB_I;
        WB_I:   state <= FETCH;
        ADDR:   state <= (op_q == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD: if (cnt_done) state <= WB_LW;
        WB_LW:  state <= FETCH;
        MEM_WR: if (cnt_done) state <= FETCH;
        BRANCH: state <= FETCH;
        JUMP:   state <= FETCH;
        HALT:   state <= HALT;
        default: state <= RST;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    halted        = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = last;
        pc_write  = last;
      end
      DECODE: alu_src_b = SRCB_BRANCH;
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      WB_R: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      EXEC_I, ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
      end
      WB_I:   reg_write = 1'b1;
      MEM_RD: i_or_d = 1'b1;
      WB_LW: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = last;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_source     = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle output vectors for each instruction class.
// Two instances cover MEM_WAIT=1 and MEM_WAIT=3 with shared stimulus.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;

  logic       pw1, pwc1, iord1, mw1, irw1, rd1, m2r1, rw1, asa1, h1;
  logic [2:0] asb1;
  logic [1:0] aop1, ps1;
  logic       pw3, pwc3, iord3, mw3, irw3, rd3, m2r3, rw3, asa3, h3;
  logic [2:0] asb3;
  logic [1:0] aop3, ps3;

  int tests_run = 0;
  int tests_failed = 0;

  // Layout: {pc_write, pc_write_cond, i_or_d, mem_write, ir_write,
  //          reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halted}
  logic [16:0] v1, v3;
  assign v1 = {pw1, pwc1, iord1, mw1, irw1, rd1, m2r1, rw1, asa1, asb1, aop1, ps1, h1};
  assign v3 = {pw3, pwc3, iord3, mw3, irw3, rd3, m2r3, rw3, asa3, asb3, aop3, ps3, h3};

  localparam logic [16:0] V_ZERO = 17'd0;
  localparam logic [16:0] V_FW   = {9'b000000000, 3'd1, 2'd0, 2'd0, 1'b0};
  localparam logic [16:0] V_FL   = {9'b100010000, 3'd1, 2'd0, 2'd0, 1'b0};
  localparam logic [16:0] V_DEC  = {9'b000000000, 3'd3, 2'd0, 2'd0, 1'b0};
  localparam logic [16:0] V_EXR  = {9'b000000001, 3'd0, 2'd2, 2'd0, 1'b0};
  localparam logic [16:0] V_WBR  = {9'b000001010, 3'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [16:0] V_ADR  = {9'b000000001, 3'd2, 2'd0, 2'd0, 1'b0};
  localparam logic [16:0] V_MRD  = {9'b001000000, 3'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [16:0] V_WBL  = {9'b000000110, 3'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [16:0] V_MWL  = {9'b001100000, 3'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [16:0] V_BR   = {9'b010000001, 3'd0, 2'd1, 2'd1, 1'b0};
  localparam logic [16:0] V_JMP  = {9'b100000000, 3'd0, 2'd0, 2'd2, 1'b0};
  localparam logic [16:0] V_HLT  = {16'd0, 1'b1};

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_WAIT(1)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_write(pw1), .pc_write_cond(pwc1), .i_or_d(iord1), .mem_write(mw1),
    .ir_write(irw1), .reg_dst(rd1), .mem_to_reg(m2r1), .reg_write(rw1),
    .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1), .pc_source(ps1), .halted(h1)
  );

  mc_control_fsm #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_write(pw3), .pc_write_cond(pwc3), .i_or_d(iord3), .mem_write(mw3),
    .ir_write(irw3), .reg_dst(rd3), .mem_to_reg(m2r3), .reg_write(rw3),
    .alu_src_a(asa3), .alu_src_b(asb3), .alu_op(aop3), .pc_source(ps3), .halted(h3)
  );

  // Leaves reset released just after a rising edge; the next falling edge is the RST cycle.
  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    opcode = 6'h00;
    @(negedge clk);
    tests_run++;
    if (v1 !== V_ZERO) begin
      tests_failed++;
      $display("FAIL reset_hold_w1 got %h want %h", v1, V_ZERO);
    end
    tests_run++;
    if (v3 !== V_ZERO) begin
      tests_failed++;
      $display("FAIL reset_hold_w3 got %h want %h", v3, V_ZERO);
    end
  endtask

  task automatic test_rtype();
    logic [16:0] exp_v [7] = '{V_ZERO, V_FW, V_FL, V_DEC, V_EXR, V_WBR, V_FW};
    int irw_cnt = 0;
    opcode = 6'h00;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 6) irw_cnt += int'(irw1);
      tests_run++;
      if (v1 !== exp_v[c]) begin
        tests_failed++;
        $display("FAIL rtype_cyc%0d got %h want %h", c, v1, exp_v[c]);
      end
    end
    tests_run++;
    if (irw_cnt != 1) begin
      tests_failed++;
      $display("FAIL rtype_ir_write_pulses got %0d want 1", irw_cnt);
    end
  endtask

  task automatic test_lw_sw();
    logic [16:0] exp_v [15] = '{V_ZERO, V_FW, V_FL, V_DEC, V_ADR, V_MRD, V_MRD, V_WBL,
                                V_FW, V_FL, V_DEC, V_ADR, V_MRD, V_MWL, V_FW};
    int mw_cnt = 0, lw_wb_cnt = 0, iord_lw = 0;
    opcode = 6'h23;
    apply_reset();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      mw_cnt += int'(mw1);
      lw_wb_cnt += int'(rw1 & m2r1);
      if (c <= 7) iord_lw += int'(iord1);
      tests_run++;
      if (v1 !== exp_v[c]) begin
        tests_failed++;
        $display("FAIL lwsw_cyc%0d got %h want %h", c, v1, exp_v[c]);
      end
      // Opcode moves to sw while lw is in ADDR: the latched lw must still pick MEM_RD.
      if (c == 3) begin
        @(posedge clk);
        #1 opcode = 6'h2B;
      end
    end
    tests_run++;
    if (mw_cnt != 1) begin
      tests_failed++;
      $display("FAIL sw_mem_write_pulses got %0d want 1", mw_cnt);
    end
    tests_run++;
    if (lw_wb_cnt != 1) begin
      tests_failed++;
      $display("FAIL lw_mdr_writes got %0d want 1", lw_wb_cnt);
    end
    tests_run++;
    if (iord_lw != 2) begin
      tests_failed++;
      $display("FAIL lw_i_or_d_cycles got %0d want 2", iord_lw);
    end
  endtask

  task automatic test_beq();
    logic [16:0] exp_v [10] = '{V_ZERO, V_FW, V_FL, V_DEC, V_BR, V_FW, V_FL, V_DEC, V_BR, V_FW};
    opcode = 6'h04;
    zero = 1'b1;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests_run++;
      if (v1 !== exp_v[c]) begin
        tests_failed++;
        $display("FAIL beq_cyc%0d zero=%0b got %h want %h", c, zero, v1, exp_v[c]);
      end
      if (c == 4) zero = 1'b0;
    end
  endtask

  task automatic test_jump_wait3();
    logic [16:0] exp_v [8] = '{V_ZERO, V_FW, V_FW, V_FW, V_FL, V_DEC, V_JMP, V_FW};
    opcode = 6'h02;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tests_run++;
      if (v3 !== exp_v[c]) begin
        tests_failed++;
        $display("FAIL jump_w3_cyc%0d got %h want %h", c, v3, exp_v[c]);
      end
    end
  endtask

  task automatic test_halt();
    logic [16:0] exp_v [4] = '{V_ZERO, V_FW, V_FL, V_DEC};
    opcode = 6'h3F;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (v1 !== exp_v[c]) begin
        tests_failed++;
        $display("FAIL halt_pre_cyc%0d got %h want %h", c, v1, exp_v[c]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 5) opcode = 6'h00;
      tests_run++;
      if (v1 !== V_HLT) begin
        tests_failed++;
        $display("FAIL halt_hold_cyc%0d got %h want %h", c, v1, V_HLT);
      end
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (v1 !== V_ZERO) begin
      tests_failed++;
      $display("FAIL halt_reset_clear got %h want %h", v1, V_ZERO);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (v1 !== V_FW) begin
      tests_failed++;
      $display("FAIL halt_refetch got %h want %h", v1, V_FW);
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] exp_v [6] = '{V_ZERO, V_FW, V_FL, V_DEC, V_ADR, V_MRD};
    logic [16:0] post_v [3] = '{V_ZERO, V_FW, V_FL};
    opcode = 6'h23;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests_run++;
      if (v1 !== exp_v[c]) begin
        tests_failed++;
        $display("FAIL midrst_pre_cyc%0d got %h want %h", c, v1, exp_v[c]);
      end
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (v1 !== V_ZERO) begin
      tests_failed++;
      $display("FAIL midrst_async_drop got %h want %h", v1, V_ZERO);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (v1 !== post_v[c]) begin
        tests_failed++;
        $display("FAIL midrst_post_cyc%0d got %h want %h", c, v1, post_v[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_sw();
    test_beq();
    test_jump_wait3();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
